// File: rtl/avalon_key_pio_db_pkg.sv
// Register map and bus widths for the debounced key PIO.
// Imported by the bus interface, the per-bit debouncer and the top level.
package key_pio_pkg;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 32;

   localparam logic [ADDR_W-1:0] ADDR_DATA = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_RAW  = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_MASK = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_EDGE = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_RISE = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_FALL = 3'd5;

endpackage

// File: rtl/avalon_key_pio_db_if.sv
// Avalon-MM slave port of the key PIO plus its level interrupt.
// The master drives the command; the slave returns registered read data and irq.
interface avalon_key_pio_db_if;
   import key_pio_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );

endinterface

// File: rtl/avalon_key_pio_db_debounce.sv
// One input bit: 2-FF synchroniser followed by a consecutive-mismatch counter.
// A change on din_async reaches stable DEBOUNCE_CYCLES+2 edges later; pulses fire on that edge.
module key_debounce_bit
   import key_pio_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic INIT_BIT        = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic din_async,
   output logic raw,
   output logic stable,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q;
   logic             s2_q;
   logic             stable_q;
   logic             stable_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             mismatch;
   logic             accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q     <= INIT_BIT;
         s2_q     <= INIT_BIT;
         stable_q <= INIT_BIT;
         cnt_q    <= '0;
      end else begin
         s1_q     <= din_async;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign mismatch = s2_q ^ stable_q;
   // cnt_q counts mismatches already seen, so the current edge is the last one when it equals N-1
   assign accept   = mismatch && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (accept) begin
         stable_d = s2_q;
      end else if (mismatch) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign raw        = s2_q;
   assign stable     = stable_q;
   assign rise_pulse = accept & s2_q;
   assign fall_pulse = accept & ~s2_q;

endmodule

// File: rtl/avalon_key_pio_db.sv
// Debounced key/switch PIO on Avalon-MM with per-bit edge select, W1C capture and masked irq.
// Read data is registered (1-cycle latency); writes take effect on the strobe edge; no wait states.
module avalon_key_pio_db
   import key_pio_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter logic [WIDTH-1:0] INIT_LEVEL      = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port,
   avalon_key_pio_db_if.slave bus
);

   logic [WIDTH-1:0]  raw;
   logic [WIDTH-1:0]  stable;
   logic [WIDTH-1:0]  rise;
   logic [WIDTH-1:0]  fall;

   logic [WIDTH-1:0]  mask_q,    mask_d;
   logic [WIDTH-1:0]  edge_q,    edge_d;
   logic [WIDTH-1:0]  rise_en_q, rise_en_d;
   logic [WIDTH-1:0]  fall_en_q, fall_en_d;
   logic [DATA_W-1:0] readdata_q, readdata_d;

   logic              wr_en;
   logic [WIDTH-1:0]  wdata;
   logic [DATA_W-1:0] wdata_unused;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      key_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .INIT_BIT        (INIT_LEVEL[i])
      ) u_db (
         .clk        (clk),
         .reset      (reset),
         .din_async  (in_port[i]),
         .raw        (raw[i]),
         .stable     (stable[i]),
         .rise_pulse (rise[i]),
         .fall_pulse (fall[i])
      );
   end

   assign wr_en        = bus.chipselect & ~bus.write_n;
   assign wdata        = bus.writedata[WIDTH-1:0];
   assign wdata_unused = bus.writedata;

   always_comb begin
      mask_d    = mask_q;
      edge_d    = edge_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      if (wr_en) begin
         case (bus.address)
            ADDR_MASK: mask_d    = wdata;
            ADDR_EDGE: edge_d    = edge_q & ~wdata;
            ADDR_RISE: rise_en_d = wdata;
            ADDR_FALL: fall_en_d = wdata;
            default:   ;
         endcase
      end
      // A new edge is OR-ed in after the clear so a simultaneous W1C cannot lose it
      edge_d = edge_d | (rise & rise_en_q) | (fall & fall_en_q);
   end

   always_comb begin
      readdata_d = '0;
      case (bus.address)
         ADDR_DATA: readdata_d[WIDTH-1:0] = stable;
         ADDR_RAW:  readdata_d[WIDTH-1:0] = raw;
         ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
         ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
         ADDR_RISE: readdata_d[WIDTH-1:0] = rise_en_q;
         ADDR_FALL: readdata_d[WIDTH-1:0] = fall_en_q;
         default:   readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q     <= '0;
         edge_q     <= '0;
         rise_en_q  <= '0;
         fall_en_q  <= '1;
         readdata_q <= '0;
      end else begin
         mask_q     <= mask_d;
         edge_q     <= edge_d;
         rise_en_q  <= rise_en_d;
         fall_en_q  <= fall_en_d;
         readdata_q <= readdata_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign bus.irq      = |(edge_q & mask_q);

endmodule

// File: doc/avalon_key_pio_db.md
Name: avalon_key_pio_db

Overview:
Parametrised successor to the audio-system pushbutton PIO. It is an Avalon-MM slave on the Nios II data bus, sampling WIDTH asynchronous key/switch inputs. Each input passes through a 2-FF synchroniser and a per-bit counter debouncer. Per-bit rising/falling edge selection, write-1-to-clear edge capture and a masked level IRQ are provided.

Parameters:
WIDTH, 4, number of input bits (1..32)
DEBOUNCE_CYCLES, 50000, consecutive clk cycles an input must differ from the debounced state before it is accepted (1 ms at 50 MHz); must be >= 1
INIT_LEVEL, {WIDTH{1'b1}}, reset value of synchroniser and debounced state (keys are active-low, so idle is high)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  3  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  WIDTH  raw asynchronous inputs
readdata  out  32  registered read data
irq  out  1  interrupt request, level

Behaviour:
- Single clock domain. Reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values:
  - readdata=0, irq=0, irq_mask=0, edge_capture=0.
  - rise_en=0, fall_en=all ones (press on active-low keys).
  - sync regs, debounced state and counters = INIT_LEVEL / 0.
- Register map (bits above WIDTH read 0; writes to those bits are ignored):
  - 0 DATA: debounced state, RO.
  - 1 RAW: synchronised undebounced input, RO.
  - 2 IRQ_MASK: RW.
  - 3 EDGE_CAPTURE: read; write-1-to-clear per bit.
  - 4 RISE_EN: RW.
  - 5 FALL_EN: RW.
  - 6, 7: read 0; writes ignored.
- Write = chipselect & ~write_n, taking effect at that clock edge.
- readdata is registered every cycle from address, independent of chipselect. Read latency is 1 cycle. Reads have no side effects.
- Synchroniser: in_port -> s1 -> s2. s2 is RAW.
- Debouncer (per bit):
  - If s2 == stable, the counter is cleared.
  - Otherwise the counter increments. On the DEBOUNCE_CYCLES-th consecutive mismatching edge, stable <= s2 and the counter is cleared.
  - Any return to s2 == stable before that point clears the counter, so no change is accepted.
  - Latency from in_port change to DATA change: DEBOUNCE_CYCLES+2 clock edges.
  - DEBOUNCE_CYCLES=1 means effectively no filtering (latency 3).
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); it never wraps because it saturates at accept.
- Edge detect:
  - Asserted on the same edge stable toggles.
  - rise = ~stable & s2 & rise_en; fall = stable & ~s2 & fall_en.
  - A detected edge sets edge_capture[i] at that edge.
- W1C on the same cycle as a new edge on the same bit: set wins (no lost event). Other bits clear normally.
- Writing 0 to any EDGE_CAPTURE bit has no effect.
- irq = |(edge_capture & irq_mask), driven combinationally from registers only (glitch-free).
  - Changing the mask affects irq in the cycle after the write.
  - Unmasking a captured bit raises irq immediately, with no new edge required.
- Changing RISE_EN/FALL_EN never modifies edge_capture or the debounce state.
- Reset mid-debounce discards the pending change. stable returns to INIT_LEVEL; if in_port differs, it is re-qualified from scratch afterwards.

Decomposition:
- Package key_pio_pkg holds:
  - ADDR_W=3.
  - Register address localparams: ADDR_DATA, ADDR_RAW, ADDR_MASK, ADDR_EDGE, ADDR_RISE, ADDR_FALL.
- Sub-module key_debounce_bit:
  - Parameters DEBOUNCE_CYCLES, INIT_BIT.
  - Ports clk, reset, din_async, raw, stable, rise_pulse, fall_pulse.
  - Contains the synchroniser and counter; instantiated WIDTH times in a generate loop.
- The top level holds the register file, read mux, capture logic and irq.

Test Plan:
All tests use WIDTH=4, DEBOUNCE_CYCLES=4, INIT_LEVEL=4'hF.
1. Reset -> readdata=0, irq=0. Read addr 0 -> 0xF; addr 4 -> 0x0; addr 5 -> 0xF.
2. in_port[1] 1->0 held -> RAW bit1=0 after 2 edges. DATA=0xD exactly 6 edges after the change. EDGE_CAPTURE=0x2; irq stays 0 (mask=0). Write MASK=0x2 -> irq=1 next cycle.
3. in_port[0] pulses low for 3 cycles, then returns high -> DATA stays 0xF, EDGE_CAPTURE bit0 stays 0, irq stays 0.
4. Edge pending on bit 1, write EDGE_CAPTURE=0x1 -> bit1 stays set. Write 0x2 -> EDGE_CAPTURE=0, irq=0 next cycle.
5. RISE_EN=0x4, FALL_EN=0x0, in_port[2] 1->0->1 with each level held for 10 cycles -> only the release sets bit2. Write 0x4 to EDGE_CAPTURE on the exact edge the release is accepted -> bit2 remains 1.
6. Assert reset 2 edges after in_port[3] falls (mid-debounce), release it, keep in_port[3]=0 -> DATA bit3 falls 6 edges after reset release. EDGE_CAPTURE=0x8 with default FALL_EN.
